// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MA stage.
// Issues RV32 byte/half/word loads and stores onto a word-addressed memory,
// extends load data, performs read-modify-write for sub-word stores, and
// reports alignment and range exceptions in a single DONE cycle.
module dmem_access_ctrl #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_read,
    input  logic                     req_write,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     busy,
    output logic                     misaligned,
    output logic                     fault,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [31:0]              mem_rdata
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [2:0]  LAT     = 3'(READ_LAT);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        RMW_WR,
        DONE
    } state_t;

    state_t         state;
    logic [2:0]     cnt;
    logic [AW-1:0]  addr_q;
    logic [1:0]     lane_q;
    logic [2:0]     f3_q;
    logic [15:0]    sdata_q;
    logic [31:0]    wword_q;

    logic req, both, legal, is_half, is_word, mis, oor;
    logic exc_mis, exc_fault, go;

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [15:0] d,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  lane);
        logic [31:0] r;
        r = w;
        if (f3 == 3'b000)
            r[{lane, 3'b000} +: 8] = d[7:0];
        else if (lane[1])
            r[31:16] = d;
        else
            r[15:0] = d;
        return r;
    endfunction

    // Classify the request presented in IDLE; earlier checks take priority.
    always_comb begin
        req     = req_read | req_write;
        both    = req_read & req_write;
        if (req_read)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        else
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        is_half   = (funct3[1:0] == 2'b01);
        is_word   = (funct3[1:0] == 2'b10);
        mis       = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        oor       = (addr[31:2] >= DEPTH_W);
        exc_fault = both | ~legal | (~mis & oor);
        exc_mis   = ~both & legal & mis;
        go        = req & ~exc_fault & ~exc_mis;
    end

    // Sequencer state, captured request fields and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
            sdata_q    <= '0;
            wword_q    <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr[AW+1:2];
                        lane_q  <= addr[1:0];
                        f3_q    <= funct3;
                        sdata_q <= wdata[15:0];
                        if (!go) begin
                            state      <= DONE;
                            misaligned <= exc_mis;
                            fault      <= exc_fault;
                        end else if (req_read) begin
                            state <= RD_WAIT;
                            cnt   <= LAT;
                        end else if (funct3 == 3'b010) begin
                            state <= DONE;
                        end else begin
                            state <= RMW_WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd1) begin
                        rdata <= load_ext(mem_rdata, f3_q, lane_q);
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RMW_WAIT: begin
                    if (cnt == 3'd1) begin
                        wword_q <= merge(mem_rdata, sdata_q, f3_q, lane_q);
                        state   <= RMW_WR;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RMW_WR:  state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes and stall; the IDLE issue path is combinational so a
    // request is launched in the same cycle it appears, and everything is
    // forced low while reset is asserted so no strobe escapes after rst_n falls.
    always_comb begin
        busy      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        if (!rst_n) begin
            mem_addr = '0;
        end else begin
            case (state)
                IDLE: begin
                    busy = req;
                    if (req)
                        mem_addr = addr[AW+1:2];
                    if (go) begin
                        if (req_read || funct3 != 3'b010) begin
                            mem_read = 1'b1;
                        end else begin
                            mem_write = 1'b1;
                            mem_wdata = wdata;
                        end
                    end
                end
                RD_WAIT, RMW_WAIT: busy = 1'b1;
                RMW_WR: begin
                    busy      = 1'b1;
                    mem_write = 1'b1;
                    mem_wdata = wword_q;
                end
                default: busy = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a synchronous 1-cycle data memory.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_read, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, misaligned, fault;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    dmem_access_ctrl #(.DEPTH(1024), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .misaligned(misaligned), .fault(fault), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model and strobe monitor
    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          read_cnt = 0, write_cnt = 0;
    logic [9:0]  last_raddr = '0, last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        both_seen = 1'b0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (mem_read) begin
            mem_rdata  <= mem[mem_addr];
            read_cnt   <= read_cnt + 1;
            last_raddr <= mem_addr;
        end
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
            write_cnt     <= write_cnt + 1;
            last_waddr    <= mem_addr;
            last_wdata    <= mem_wdata;
        end
        if (mem_read && mem_write) both_seen <= 1'b1;
    end

    task automatic idle();
        req_read = 1'b0; req_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        req_read = 1'b0; req_write = 1'b0;
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Presents one request (called just after a rising edge) and follows it to DONE.
    task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int bcyc, output logic [31:0] rd_o,
                           output logic mis_o, output logic flt_o,
                           output int nrd, output int nwr,
                           output logic done_strobe, output logic timeout);
        int r0, w0;
        req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        r0 = read_cnt; w0 = write_cnt;
        bcyc = 0; timeout = 1'b1; done_strobe = 1'b0;
        rd_o = '0; mis_o = 1'b0; flt_o = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            else begin
                rd_o = rdata; mis_o = misaligned; flt_o = fault;
                done_strobe = mem_read | mem_write;
                timeout = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        nrd = read_cnt - r0;
        nwr = write_cnt - w0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0;
        funct3 = '0; addr = '0; wdata = '0;
        #3;
        vectors++;
        if ({busy, mem_read, mem_write, misaligned, fault} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_read, mem_write, misaligned, fault});
        end
        vectors++;
        if ({rdata, mem_wdata, mem_addr} !== 74'h0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h mem_wdata=%h mem_addr=%h want 0", rdata, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        int b, nr, nw; logic [31:0] r; logic m, f, ds, to;
        preload(10'd4, 32'hDEADBEEF);
        run_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, b, r, m, f, nr, nw, ds, to);
        vectors++;
        if (to !== 1'b0 || b != 2) begin
            miscompares++;
            $display("FAIL lw_busy: busy cycles %0d timeout %b want 2", b, to);
        end
        vectors++;
        if (r !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_rdata: got %h want deadbeef", r);
        end
        vectors++;
        if (nr != 1 || nw != 0 || last_raddr !== 10'd4) begin
            miscompares++;
            $display("FAIL lw_strobe: reads %0d writes %0d addr %0d want 1 0 4", nr, nw, last_raddr);
        end
        idle();
    endtask

    task automatic test_subword_load();
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        int b, nr, nw; logic [31:0] r; logic m, f, ds, to;
        preload(10'd4, 32'h80FF0011);
        for (int i = 0; i < 4; i++) begin
            run_req(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, b, r, m, f, nr, nw, ds, to);
            vectors++;
            if (to !== 1'b0 || r !== exps[i] || b != 2) begin
                miscompares++;
                $display("FAIL subload_%0d: rdata %h busy %0d want %h 2", i, r, b, exps[i]);
            end
        end
        idle();
    endtask

    task automatic test_stores();
        int b, nr, nw; logic [31:0] r; logic m, f, ds, to;
        logic [31:0] prev;
        preload(10'd4, 32'h11223344);
        prev = rdata;
        run_req(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFFAB, b, r, m, f, nr, nw, ds, to);
        vectors++;
        if (to !== 1'b0 || b != 3 || nw != 1 || nr != 1) begin
            miscompares++;
            $display("FAIL sb_seq: busy %0d reads %0d writes %0d want 3 1 1", b, nr, nw);
        end
        vectors++;
        if (last_wdata !== 32'h1122AB44 || last_waddr !== 10'd4) begin
            miscompares++;
            $display("FAIL sb_data: wdata %h addr %0d want 1122ab44 4", last_wdata, last_waddr);
        end
        vectors++;
        if (r !== prev) begin
            miscompares++;
            $display("FAIL sb_rdata_hold: got %h want %h", r, prev);
        end
        idle();
        run_req(1'b0, 1'b1, 3'b001, 32'h12, 32'h00005566, b, r, m, f, nr, nw, ds, to);
        vectors++;
        if (to !== 1'b0 || b != 3 || nw != 1 || last_wdata !== 32'h5566AB44) begin
            miscompares++;
            $display("FAIL sh_data: busy %0d writes %0d wdata %h want 3 1 5566ab44", b, nw, last_wdata);
        end
        idle();
        run_req(1'b0, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, b, r, m, f, nr, nw, ds, to);
        vectors++;
        if (to !== 1'b0 || b != 1 || nw != 1 || nr != 0 || last_waddr !== 10'd5) begin
            miscompares++;
            $display("FAIL sw_seq: busy %0d reads %0d writes %0d addr %0d want 1 0 1 5", b, nr, nw, last_waddr);
        end
        idle();
        run_req(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, b, r, m, f, nr, nw, ds, to);
        vectors++;
        if (r !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL sw_readback: got %h want cafef00d", r);
        end
        idle();
    endtask

    task automatic test_exceptions();
        logic        rds [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        wrs [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [7] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b001};
        logic [31:0] ads [7] = '{32'h12, 32'h01, 32'h1000, 32'h10, 32'h10, 32'h10, 32'h1001};
        logic        em  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ef  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int b, nr, nw; logic [31:0] r; logic m, f, ds, to;
        for (int i = 0; i < 7; i++) begin
            run_req(rds[i], wrs[i], f3s[i], ads[i], 32'h0, b, r, m, f, nr, nw, ds, to);
            vectors++;
            if (to !== 1'b0 || b != 1 || m !== em[i] || f !== ef[i] || nr != 0 || nw != 0) begin
                miscompares++;
                $display("FAIL exc_%0d: busy %0d mis %b flt %b rd %0d wr %0d want 1 %b %b 0 0",
                         i, b, m, f, nr, nw, em[i], ef[i]);
            end
            vectors++;
            if (misaligned !== 1'b0 || fault !== 1'b0) begin
                miscompares++;
                $display("FAIL exc_clear_%0d: mis %b flt %b want 0 0", i, misaligned, fault);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        int b1, b2, nr1, nw1, nr2, nw2; logic [31:0] r; logic m, f, ds1, ds2, to1, to2;
        run_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, b1, r, m, f, nr1, nw1, ds1, to1);
        run_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, b2, r, m, f, nr2, nw2, ds2, to2);
        vectors++;
        if (to1 || to2 || nw1 != 1 || nr1 != 0 || nr2 != 1 || nw2 != 0) begin
            miscompares++;
            $display("FAIL b2b_count: sw r%0d w%0d lw r%0d w%0d want 0 1 1 0", nr1, nw1, nr2, nw2);
        end
        vectors++;
        if (ds1 !== 1'b0 || ds2 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done_strobe: got %b %b want 0 0", ds1, ds2);
        end
        vectors++;
        if (r !== 32'h12345678 || b1 != 1 || b2 != 2) begin
            miscompares++;
            $display("FAIL b2b_data: rdata %h busy %0d %0d want 12345678 1 2", r, b1, b2);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int b, nr, nw, w0; logic [31:0] r; logic m, f, ds, to;
        preload(10'd4, 32'h11223344);
        req_read = 1'b0; req_write = 1'b1; funct3 = 3'b000; addr = 32'h11; wdata = 32'hAB;
        @(posedge clk); #1;
        w0 = write_cnt;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, mem_read, mem_write} !== 3'b0 || mem_addr !== 10'd0 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_out: busy %b rd %b wr %b addr %0d rdata %h want all 0",
                     busy, mem_read, mem_write, mem_addr, rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (write_cnt != w0) begin
            miscompares++;
            $display("FAIL midreset_nowrite: writes %0d want 0", write_cnt - w0);
        end
        rst_n = 1'b1;
        run_req(1'b0, 1'b1, 3'b000, 32'h11, 32'hAB, b, r, m, f, nr, nw, ds, to);
        vectors++;
        if (to !== 1'b0 || b != 3 || nw != 1 || last_wdata !== 32'h1122AB44) begin
            miscompares++;
            $display("FAIL midreset_resume: busy %0d writes %0d wdata %h want 3 1 1122ab44", b, nw, last_wdata);
        end
        idle();
        vectors++;
        if (both_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL strobe_overlap: got %b want 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_subword_load();
        test_stores();
        test_exceptions();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
